// File: rtl/pe_ctrl.sv
// rtl/pe_ctrl.sv - sequencer for one PE convolution datapath (pe_dp)
//
// Walks 4x4 windows of an IMG_SIZE x IMG_SIZE image at step STRIDE. For each
// window: clear accumulators, stream 16 taps, store the sum into a result lane.
// Every 4 lanes (or the final partial group) the packed word is written to PE
// memory. Optional build macro PE_CTRL_FILE_DUMP_EN adds a one-cycle memory dump
// pulse after the last write.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a layer pass (accepted in IDLE or DONE only)
//   busy, done        scheduler handshake
//   rst_acc, acc_en   MAC accumulator clear / accumulate enable
//   res_buffer_en     latch macs_sum into lane res_index
//   rst_res_reg       clear the 4-word result register
//   wr_en, wr_adr     write packed result word to mem[wr_adr]
//   wr_file           one-cycle memory dump pulse
//   img_buffer_index  top-left pixel index of the current window
//   buffer_cntr       tap index 0..15 within the window
//   res_index         result lane 0..3
module pe_ctrl #(
  parameter int IMG_SIZE     = 16,
  parameter int STRIDE       = 4,
  parameter int MAX_MEM_SIZE = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rst_acc,
  output logic       acc_en,
  output logic       res_buffer_en,
  output logic       rst_res_reg,
  output logic       wr_en,
  output logic       wr_file,
  output logic [7:0] img_buffer_index,
  output logic [7:0] buffer_cntr,
  output logic [7:0] res_index,
  output logic [7:0] wr_adr
);

  localparam int WPR      = (IMG_SIZE - 4) / STRIDE + 1;
  localparam int NWIN     = WPR * WPR;
  localparam int NWORD    = (NWIN + 3) / 4;
  localparam int ROW_STEP = STRIDE * IMG_SIZE;
  localparam logic [7:0] WPR_M1 = 8'(WPR - 1);

  generate
    if (NWORD > MAX_MEM_SIZE) begin : g_mem_check
      $error("pe_ctrl: result words exceed MAX_MEM_SIZE");
    end
  endgenerate

`ifdef PE_CTRL_FILE_DUMP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_STORE, S_WRITE, S_DONE, S_DUMP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MAC, S_STORE, S_WRITE, S_DONE
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_row;
  logic [7:0]  r_col;
  logic [3:0]  r_tap;
  logic [1:0]  r_lane;
  logic [7:0]  r_word;
  logic        w_last_win;
  logic        w_group_end;
  logic [31:0] w_img_full;

  assign w_last_win  = (r_row == WPR_M1) && (r_col == WPR_M1);
  assign w_group_end = (r_lane == 2'd3) || w_last_win;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_MAC;
      S_MAC:   if (r_tap == 4'd15) w_next = S_STORE;
      S_STORE: w_next = w_group_end ? S_WRITE : S_CLEAR;
      S_WRITE: begin
        if (w_last_win) begin
`ifdef PE_CTRL_FILE_DUMP_EN
          w_next = S_DUMP;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_CLEAR;
        end
      end
`ifdef PE_CTRL_FILE_DUMP_EN
      S_DUMP:  w_next = S_DONE;
`endif
      S_DONE:  if (start) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  // Window, tap, lane and word counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= 8'd0;
      r_col  <= 8'd0;
      r_tap  <= 4'd0;
      r_lane <= 2'd0;
      r_word <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_row  <= 8'd0;
            r_col  <= 8'd0;
            r_tap  <= 4'd0;
            r_lane <= 2'd0;
            r_word <= 8'd0;
          end
        end
        // 4-bit tap counter wraps 15 -> 0 exactly on the MAC-to-STORE edge
        S_MAC: r_tap <= r_tap + 4'd1;
        S_STORE: begin
          if (!w_group_end) begin
            r_lane <= r_lane + 2'd1;
            if (r_col == WPR_M1) begin
              r_col <= 8'd0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        S_WRITE: begin
          r_word <= r_word + 8'd1;
          r_lane <= 2'd0;
          if (!w_last_win) begin
            if (r_col == WPR_M1) begin
              r_col <= 8'd0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded purely from registers
  assign w_img_full = 32'(r_row) * 32'(ROW_STEP) + 32'(r_col) * 32'(STRIDE);

  assign busy             = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done             = (r_state == S_DONE);
  assign rst_acc          = (r_state == S_CLEAR);
  assign rst_res_reg      = (r_state == S_CLEAR) && (r_lane == 2'd0);
  assign acc_en           = (r_state == S_MAC);
  assign res_buffer_en    = (r_state == S_STORE);
  assign wr_en            = (r_state == S_WRITE);
  // r_word already points past the last word after the final WRITE
  assign wr_adr           = (r_state == S_WRITE) ? r_word : 8'd0;
`ifdef PE_CTRL_FILE_DUMP_EN
  assign wr_file          = (r_state == S_DUMP);
`else
  assign wr_file          = 1'b0;
`endif
  assign img_buffer_index = w_img_full[7:0];
  assign buffer_cntr      = {4'd0, r_tap};
  assign res_index        = {6'd0, r_lane};

endmodule
